reg_seq_ctrl: RTL and testbench

REG_SEQ_CTRL -- requirements
Module: reg_seq_ctrl

---
 rtl/reg_seq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_reg_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// reg_seq_ctrl
// Small register-sequencing controller: accepts one 8-bit instruction at a
// time, reads a 4-entry external register group through rf_sr/rf_dr, computes
// an 8-bit result and writes it back with a single-cycle rf_we pulse.
//
// Sequence per instruction: IDLE -> DECODE -> EXEC (1+WAIT_CYCLES) -> WRITE.
// rf_we, done and err are flop outputs so the register group can capture them
// on the falling edge without seeing decode glitches.
//
// Optional feature: define REG_SEQ_FLAGS_EN to build registered zero/carry
// flags. Without it, flag_z and flag_c are constant 0 and no flag flops exist.
// -----------------------------------------------------------------------------
module reg_seq_ctrl #(
    parameter int unsigned WAIT_CYCLES = 0  // extra EXEC stall cycles, 0..3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    input  logic [7:0] imm,
    output logic       instr_ready,
    input  logic [7:0] s_in,
    input  logic [7:0] d_in,
    output logic       rf_we,
    output logic [1:0] rf_sr,
    output logic [1:0] rf_dr,
    output logic [7:0] rf_wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       flag_z,
    output logic       flag_c
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WRITE
    } state_e;

    localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYCLES);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] instr_q;
    logic [7:0] imm_q;
    logic [7:0] result_q;
    logic       ready_q;
    logic       we_q;
    logic       done_q;
    logic       err_q;

    logic       accept;
    logic       exec_last;
    logic [3:0] opcode;
    logic       wr_op;
    logic       illegal_op;
    logic [7:0] alu_res;

    assign accept     = instr_valid & ready_q;
    assign opcode     = instr_q[7:4];
    assign wr_op      = (opcode != 4'h0) && (opcode <= 4'h8);
    assign illegal_op = (opcode > 4'h8);

    // Result datapath: combinational on the latched instruction and the
    // register group's read data (which follows rf_sr/rf_dr).
    // NOTE: every combinational output is given a default before the case so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_res = 8'h00;
        unique case (opcode)
            4'h1:    alu_res = s_in;
            4'h2:    alu_res = d_in + s_in;
            4'h3:    alu_res = d_in - s_in;
            4'h4:    alu_res = d_in & s_in;
            4'h5:    alu_res = d_in | s_in;
            4'h6:    alu_res = ~s_in;
            4'h7:    alu_res = d_in + 8'h01;
            4'h8:    alu_res = imm_q;
            default: alu_res = 8'h00;
        endcase
    end

    // Sequencer next state and EXEC stall counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exec_last = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
                cnt_d   = WAIT_INIT;
            end
            S_EXEC: begin
                if (cnt_q == 2'd0) begin
                    exec_last = 1'b1;
                    state_d   = S_WRITE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and stall counter.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement or process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the instruction and immediate only on handshake, so later
    // changes on the bus cannot disturb the operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 8'h00;
            imm_q   <= 8'h00;
        end else if (accept) begin
            instr_q <= instr;
            imm_q   <= imm;
        end
    end

    // Result is frozen on the final EXEC cycle and presented during WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 8'h00;
        end else if (exec_last) begin
            result_q <= alu_res;
        end
    end

    // Registered handshake and strobe outputs. ready stays low through reset
    // and rises on the first edge after release; strobes are high only while
    // the sequencer sits in WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= (state_d == S_IDLE);
            we_q    <= exec_last & wr_op;
            done_q  <= exec_last;
            err_q   <= exec_last & illegal_op;
        end
    end

`ifdef REG_SEQ_FLAGS_EN
    logic alu_carry;
    logic flag_z_q;
    logic flag_c_q;

    // Carry out of ADD/INC, borrow for SUB, clear for every other operation.
    always_comb begin
        alu_carry = 1'b0;
        unique case (opcode)
            4'h2:    alu_carry = ({1'b0, d_in} + {1'b0, s_in}) > 9'h0FF;
            4'h3:    alu_carry = (d_in < s_in);
            4'h7:    alu_carry = (d_in == 8'hFF);
            default: alu_carry = 1'b0;
        endcase
    end

    // Flags load together with the write strobe and hold across NOP,
    // illegal opcodes and idle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (exec_last && wr_op) begin
            flag_z_q <= (alu_res == 8'h00);
            flag_c_q <= alu_carry;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

    assign instr_ready = ready_q;
    assign busy        = (state_q != S_IDLE);
    assign rf_sr       = (state_q == S_IDLE) ? 2'b00 : instr_q[1:0];
    assign rf_dr       = (state_q == S_IDLE) ? 2'b00 : instr_q[3:2];
    assign rf_we       = we_q;
    assign rf_wdata    = result_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_seq_ctrl
// Two controllers (WAIT_CYCLES = 0 and 3) run the same instruction stream in
// lockstep, each against its own 4-entry register group that writes on the
// falling edge. Expected results come from a hand-written vector table and
// from an arithmetic model of the instruction set. Build with
// +define+REG_SEQ_FLAGS_EN to check the flag option.
// -----------------------------------------------------------------------------
module tb_reg_seq_ctrl;

`ifdef REG_SEQ_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, v3;
    logic [7:0] instr, imm;

    logic       rdy0, we0, busy0, done0, err0, z0, c0;
    logic [1:0] sr0, dr0;
    logic [7:0] si0, di0, wd0;
    logic       rdy3, we3, busy3, done3, err3, z3, c3;
    logic [1:0] sr3, dr3;
    logic [7:0] si3, di3, wd3;

    logic [7:0]  rf0 [4];
    logic [7:0]  rf3 [4];
    logic        preset_en;
    logic [31:0] preset_val;

    logic [7:0] mrf [4];
    bit         mz, mc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_seq_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v0), .instr(instr), .imm(imm),
        .instr_ready(rdy0), .s_in(si0), .d_in(di0), .rf_we(we0), .rf_sr(sr0),
        .rf_dr(dr0), .rf_wdata(wd0), .busy(busy0), .done(done0), .err(err0),
        .flag_z(z0), .flag_c(c0)
    );

    reg_seq_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v3), .instr(instr), .imm(imm),
        .instr_ready(rdy3), .s_in(si3), .d_in(di3), .rf_we(we3), .rf_sr(sr3),
        .rf_dr(dr3), .rf_wdata(wd3), .busy(busy3), .done(done3), .err(err3),
        .flag_z(z3), .flag_c(c3)
    );

    assign si0 = rf0[sr0];
    assign di0 = rf0[dr0];
    assign si3 = rf3[sr3];
    assign di3 = rf3[dr3];

    // Register groups: preload from the bench, otherwise write on negedge.
    always @(negedge clk) begin
        if (preset_en) begin
            for (int i = 0; i < 4; i++) begin
                rf0[i] <= preset_val[8*i +: 8];
                rf3[i] <= preset_val[8*i +: 8];
            end
        end else begin
            if (we0) rf0[dr0] <= wd0;
            if (we3) rf3[dr3] <= wd3;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic preset(input logic [31:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        @(negedge clk);
        #1 preset_en = 1'b0;
        for (int i = 0; i < 4; i++) mrf[i] = v[8*i +: 8];
    endtask

    // Instruction-set model: integer arithmetic, then reduce modulo 256.
    task automatic model_step(input logic [7:0] ins, input logic [7:0] im,
                              output bit e_we, output bit e_err, output logic [7:0] e_res);
        int d, s, r;
        bit cy;
        d = int'(mrf[ins[3:2]]);
        s = int'(mrf[ins[1:0]]);
        r = 0; cy = 1'b0; e_we = 1'b1; e_err = 1'b0;
        case (ins[7:4])
            4'h0: e_we = 1'b0;
            4'h1: r = s;
            4'h2: begin r = d + s; cy = (r > 255); end
            4'h3: begin r = d - s; cy = (r < 0);   end
            4'h4: r = d & s;
            4'h5: r = d | s;
            4'h6: r = 255 - s;
            4'h7: begin r = d + 1; cy = (r > 255); end
            4'h8: r = int'(im);
            default: begin e_we = 1'b0; e_err = 1'b1; end
        endcase
        r = (r + 256) % 256;
        e_res = 8'(r);
        if (e_we) begin
            mrf[ins[3:2]] = e_res;
            if (FLAGS) begin
                mz = (e_res == 8'h00);
                mc = cy;
            end
        end
    endtask

    // Issue one instruction to both controllers and watch them for 10 cycles,
    // keeping instr_valid high with junk on the bus while each is busy.
    task automatic run(input string nm, input logic [7:0] ins, input logic [7:0] im,
                       input bit e_we, input bit e_err, input logic [7:0] e_res,
                       input bit e_z, input bit e_c);
        int dat0, dat3, nd0, nd3, nw0, nw3;
        logic bz0, bz3, rd0, rd3, wec0, wec3, erc0, erc3;
        logic [7:0] wdc0, wdc3;
        logic [1:0] drc0, drc3, src0, src3;
        dat0 = -1; dat3 = -1; nd0 = 0; nd3 = 0; nw0 = 0; nw3 = 0;
        bz0 = 0; bz3 = 0; rd0 = 0; rd3 = 0; wec0 = 0; wec3 = 0; erc0 = 0; erc3 = 0;
        wdc0 = 0; wdc3 = 0; drc0 = 0; drc3 = 0; src0 = 0; src3 = 0;
        @(negedge clk);
        check({nm, " ready0 before"}, 32'(rdy0), 32'd1);
        check({nm, " ready3 before"}, 32'(rdy3), 32'd1);
        instr = ins; imm = im; v0 = 1'b1; v3 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin bz0 = busy0; bz3 = busy3; end
            if (k == 4) rd0 = rdy0 & ~busy0;
            if (k == 7) rd3 = rdy3 & ~busy3;
            if (we0) nw0++;
            if (we3) nw3++;
            if (done0) begin
                nd0++;
                if (dat0 < 0) begin
                    dat0 = k; wec0 = we0; erc0 = err0; wdc0 = wd0; drc0 = dr0; src0 = sr0;
                end
                v0 = 1'b0;
            end
            if (done3) begin
                nd3++;
                if (dat3 < 0) begin
                    dat3 = k; wec3 = we3; erc3 = err3; wdc3 = wd3; drc3 = dr3; src3 = sr3;
                end
                v3 = 1'b0;
            end
            instr = 8'($urandom);
            imm   = 8'($urandom);
        end
        v0 = 1'b0; v3 = 1'b0;
        check({nm, " busy0"}, 32'(bz0), 32'd1);
        check({nm, " busy3"}, 32'(bz3), 32'd1);
        check({nm, " done0 latency"}, 32'(dat0), 32'd3);
        check({nm, " done3 latency"}, 32'(dat3), 32'd6);
        check({nm, " done0 pulses"}, 32'(nd0), 32'd1);
        check({nm, " done3 pulses"}, 32'(nd3), 32'd1);
        check({nm, " we0 pulses"}, 32'(nw0), 32'(e_we));
        check({nm, " we3 pulses"}, 32'(nw3), 32'(e_we));
        check({nm, " we0 with done"}, 32'(wec0), 32'(e_we));
        check({nm, " we3 with done"}, 32'(wec3), 32'(e_we));
        check({nm, " err0"}, 32'(erc0), 32'(e_err));
        check({nm, " err3"}, 32'(erc3), 32'(e_err));
        check({nm, " dr0"}, 32'(drc0), 32'(ins[3:2]));
        check({nm, " sr3"}, 32'(src3), 32'(ins[1:0]));
        check({nm, " dr3"}, 32'(drc3), 32'(ins[3:2]));
        check({nm, " sr0"}, 32'(src0), 32'(ins[1:0]));
        if (e_we) begin
            check({nm, " wdata0"}, 32'(wdc0), 32'(e_res));
            check({nm, " wdata3"}, 32'(wdc3), 32'(e_res));
        end
        check({nm, " ready0 after"}, 32'(rd0), 32'd1);
        check({nm, " ready3 after"}, 32'(rd3), 32'd1);
        check({nm, " flags0"}, {30'd0, z0, c0}, {30'd0, e_z, e_c});
        check({nm, " flags3"}, {30'd0, z3, c3}, {30'd0, e_z, e_c});
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s rf0[%0d]", nm, i), 32'(rf0[i]), 32'(mrf[i]));
            check($sformatf("%s rf3[%0d]", nm, i), 32'(rf3[i]), 32'(mrf[i]));
        end
    endtask

    typedef struct {
        string       nm;
        logic [31:0] pre;   // {R3, R2, R1, R0}
        logic [7:0]  ins;
        logic [7:0]  im;
        bit          we;
        bit          er;
        logic [7:0]  res;
        bit          z;     // expected flags when the flag option is built
        bit          c;
    } vec_t;

    vec_t tbl [12];

    initial begin
        bit         m_we, m_er;
        logic [7:0] m_res, ins, im;

        tbl[0]  = '{"add r3r0",  32'h07000001, 8'h2C, 8'h00, 1, 0, 8'h08, 0, 0};
        tbl[1]  = '{"inc r1 ff", 32'h0000FF00, 8'h74, 8'h00, 1, 0, 8'h00, 1, 1};
        tbl[2]  = '{"sub borrow",32'h00030005, 8'h38, 8'h00, 1, 0, 8'hFE, 0, 1};
        tbl[3]  = '{"illegal",   32'h00030005, 8'hF0, 8'h00, 0, 1, 8'h00, 0, 1};
        tbl[4]  = '{"nop",       32'h00030005, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1};
        tbl[5]  = '{"ldi r0",    32'h00000000, 8'h80, 8'h5A, 1, 0, 8'h5A, 0, 0};
        tbl[6]  = '{"mov zero",  32'h00000077, 8'h11, 8'h00, 1, 0, 8'h00, 1, 0};
        tbl[7]  = '{"and",       32'h3CF00000, 8'h4B, 8'h00, 1, 0, 8'h30, 0, 0};
        tbl[8]  = '{"or",        32'h3CF00000, 8'h5B, 8'h00, 1, 0, 8'hFC, 0, 0};
        tbl[9]  = '{"not",       32'h3CF00000, 8'h67, 8'h00, 1, 0, 8'hC3, 0, 0};
        tbl[10] = '{"add wrap",  32'h00008080, 8'h21, 8'h00, 1, 0, 8'h00, 1, 1};
        tbl[11] = '{"sub equal", 32'h00004444, 8'h31, 8'h00, 1, 0, 8'h00, 1, 0};

        rst_n = 1'b0; v0 = 1'b0; v3 = 1'b0; instr = 8'h00; imm = 8'h00;
        preset_en = 1'b0; preset_val = 32'h0; mz = 1'b0; mc = 1'b0;
        preset(32'h0);
        repeat (2) @(negedge clk);
        check("reset outputs dut0", {9'd0, rdy0, busy0, done0, err0, we0, sr0, dr0, wd0, z0, c0}, 32'd0);
        check("reset outputs dut3", {9'd0, rdy3, busy3, done3, err3, we3, sr3, dr3, wd3, z3, c3}, 32'd0);
        rst_n = 1'b1;
        #1 check("ready low before first edge", 32'(rdy0 | rdy3), 32'd0);
        @(negedge clk);
        check("ready after release", {30'd0, rdy0, rdy3}, 32'd3);

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            preset(tbl[i].pre);
            model_step(tbl[i].ins, tbl[i].im, m_we, m_er, m_res);
            run(tbl[i].nm, tbl[i].ins, tbl[i].im, tbl[i].we, tbl[i].er, tbl[i].res,
                tbl[i].z & FLAGS, tbl[i].c & FLAGS);
        end

        // Random instruction stream against the model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) preset($urandom);
            ins = {4'($urandom_range(0, 15)), 4'($urandom)};
            im  = 8'($urandom);
            model_step(ins, im, m_we, m_er, m_res);
            run($sformatf("rand%0d op%0h", n, ins[7:4]), ins, im, m_we, m_er, m_res, mz, mc);
        end

        // Reset asserted while both controllers are in EXEC.
        preset(32'h11223344);
        @(negedge clk);
        instr = 8'h84; imm = 8'hAA; v0 = 1'b1; v3 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0; v3 = 1'b0;
        check("busy before abort", {30'd0, busy0, busy3}, 32'd3);
        rst_n = 1'b0;
        #1 check("abort outputs dut0", {9'd0, rdy0, busy0, done0, err0, we0, sr0, dr0, wd0, z0, c0}, 32'd0);
        check("abort outputs dut3", {9'd0, rdy3, busy3, done3, err3, we3, sr3, dr3, wd3, z3, c3}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no strobe in reset", {28'd0, we0, we3, done0, done3}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after abort", {28'd0, rdy0, rdy3, busy0, busy3}, 32'hC);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort rf0[%0d]", i), 32'(rf0[i]), 32'(mrf[i]));
            check($sformatf("abort rf3[%0d]", i), 32'(rf3[i]), 32'(mrf[i]));
        end
        mz = 1'b0; mc = 1'b0;
        model_step(8'h88, 8'h3C, m_we, m_er, m_res);
        run("ldi after abort", 8'h88, 8'h3C, m_we, m_er, m_res, mz, mc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
